address_decoder: RTL and testbench

- Splits an 8-bit command frame, delivered by a serial receiver with a `frame_valid` strobe, into an address field and a data field.
- Holds the decoded pair stable with `valid` asserted until the downstream register block returns `ack`.
- Sits between the UART/frame receiver and the VGA control-register file.

---
 rtl/vga_ctrl_pkg.sv | 16 +
 rtl/edge_detect_rise.sv | 15 +
 rtl/address_decoder.sv | 61 ++++++
 tb/tb_address_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_ctrl_pkg.sv
// vga_ctrl_pkg: shared widths, decoder state type and control-register map for the VGA control path.
package vga_ctrl_pkg;
    localparam int DEC_FRAME_W = 8;
    localparam int DEC_ADDR_W  = 4;
    localparam int DEC_DATA_W  = 4;

    typedef enum logic {IDLE, PENDING} dec_state_t;

    // Control-register addresses carried in the frame's address field
    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_MODE     = 4'h1;
    localparam logic [3:0] REG_FG_COLOR = 4'h2;
    localparam logic [3:0] REG_BG_COLOR = 4'h3;
    localparam logic [3:0] REG_CURSOR_X = 4'h4;
    localparam logic [3:0] REG_CURSOR_Y = 4'h5;
endpackage

// File: rtl/edge_detect_rise.sv
// edge_detect_rise: one-cycle rising-edge strobe from a level, using a registered history bit.
module edge_detect_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig_i;

    assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/address_decoder.sv
// address_decoder: splits a received frame into address/data and holds it valid until acked,
// flagging frames dropped while one is still pending.
module address_decoder
    import vga_ctrl_pkg::*;
#(
    parameter int FRAME_W = DEC_FRAME_W,
    parameter int ADDR_W  = DEC_ADDR_W,
    parameter int DATA_W  = DEC_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame,
    input  logic               frame_valid,
    input  logic               ack,
    output logic [ADDR_W-1:0]  address,
    output logic [DATA_W-1:0]  data,
    output logic               valid,
    output logic               overrun
);
    dec_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overrun_q, overrun_d;
    logic              new_frame, capture;

    edge_detect_rise u_fv_edge (
        .clk    (clk),
        .rst_n  (rst),
        .sig_i  (frame_valid),
        .rise_o (new_frame)
    );

    // A pending frame can only be replaced when the same edge also acknowledges it
    always_comb begin
        capture   = new_frame & ((state_q == IDLE) | ack);
        addr_d    = capture ? frame[FRAME_W-1 -: ADDR_W] : addr_q;
        data_d    = capture ? frame[DATA_W-1:0] : data_q;
        state_d   = (state_q == IDLE) ? (new_frame ? PENDING : IDLE)
                                      : ((ack & ~new_frame) ? IDLE : PENDING);
        overrun_d = (state_q == PENDING) & new_frame & ~ack;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign address = addr_q;
    assign data    = data_q;
    assign valid   = (state_q == PENDING);
    assign overrun = overrun_q;
endmodule

// File: tb/tb_address_decoder.sv
// tb_address_decoder: scenario tasks drive frames; accepted frames go through a scoreboard queue.
module tb_address_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] frame = 8'h00;
    logic       frame_valid = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] address, data;
    logic       valid, overrun;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_f;
    logic [9:0] got, want;

    address_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .frame_valid (frame_valid),
        .ack         (ack),
        .address     (address),
        .data        (data),
        .valid       (valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            frame = 8'(i * 8'h3B);
            frame_valid = i[0];
            tick();
            got = {address, data, valid, overrun};
            checks++;
            if (got !== 10'h000) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, got, 10'h000);
            end
        end
        frame_valid = 1'b0;
        frame = 'x;
        tick();
        rst = 1'b1;
        tick();
        got = {address, data, valid, overrun};
        checks++;
        if (got !== 10'h000) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", got, 10'h000);
        end
    endtask

    task automatic test_basic();
        frame = 8'b1001_0010;
        frame_valid = 1'b1;
        exp_q.push_back(frame);
        tick();
        frame_valid = 1'b0;
        frame = 'x;
        exp_f = exp_q.pop_front();
        want = {exp_f, 2'b10};
        got = {address, data, valid, overrun};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL basic_capture: got %h expected %h", got, want);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            got = {address, data, valid, overrun};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL basic_hold[%0d]: got %h expected %h", i, got, want);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        want = {exp_f, 2'b00};
        got = {address, data, valid, overrun};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL basic_ack: got %h expected %h", got, want);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        got = {address, data, valid, overrun};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL idle_ack_ignored: got %h expected %h", got, want);
        end
    endtask

    task automatic test_second_frame();
        tick();
        tick();
        frame = 8'b1010_1010;
        frame_valid = 1'b1;
        exp_q.push_back(frame);
        tick();
        frame_valid = 1'b0;
        frame = 'x;
        exp_f = exp_q.pop_front();
        want = {exp_f, 2'b10};
        for (int i = 0; i < 3; i++) begin
            got = {address, data, valid, overrun};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL second_frame[%0d]: got %h expected %h", i, got, want);
            end
            tick();
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        got = {address, data, valid, overrun};
        checks++;
        if (got !== {exp_f, 2'b00}) begin
            failures++;
            $display("FAIL second_ack: got %h expected %h", got, {exp_f, 2'b00});
        end
    endtask

    task automatic test_long_strobe();
        frame = 8'h5C;
        frame_valid = 1'b1;
        exp_q.push_back(frame);
        tick();
        exp_f = exp_q.pop_front();
        got = {address, data, valid, overrun};
        checks++;
        if (got !== {exp_f, 2'b10}) begin
            failures++;
            $display("FAIL long_capture: got %h expected %h", got, {exp_f, 2'b10});
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = {address, data, valid, overrun};
            checks++;
            if (got !== {exp_f, 2'b00}) begin
                failures++;
                $display("FAIL long_no_recapture[%0d]: got %h expected %h", i, got, {exp_f, 2'b00});
            end
            tick();
        end
        frame_valid = 1'b0;
        tick();
    endtask

    task automatic test_overrun_and_b2b();
        frame = 8'h31;
        frame_valid = 1'b1;
        exp_q.push_back(frame);
        tick();
        frame_valid = 1'b0;
        exp_f = exp_q.pop_front();
        tick();
        frame = 8'h7E;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        got = {address, data, valid, overrun};
        checks++;
        if (got !== {exp_f, 2'b11}) begin
            failures++;
            $display("FAIL overrun_pulse: got %h expected %h", got, {exp_f, 2'b11});
        end
        tick();
        got = {address, data, valid, overrun};
        checks++;
        if (got !== {exp_f, 2'b10}) begin
            failures++;
            $display("FAIL overrun_one_cycle: got %h expected %h", got, {exp_f, 2'b10});
        end
        frame = 8'hF0;
        frame_valid = 1'b1;
        ack = 1'b1;
        exp_q.push_back(frame);
        tick();
        frame_valid = 1'b0;
        ack = 1'b0;
        exp_f = exp_q.pop_front();
        got = {address, data, valid, overrun};
        checks++;
        if (got !== {exp_f, 2'b10}) begin
            failures++;
            $display("FAIL back_to_back: got %h expected %h", got, {exp_f, 2'b10});
        end
        tick();
        got = {address, data, valid, overrun};
        checks++;
        if (got !== {exp_f, 2'b10}) begin
            failures++;
            $display("FAIL b2b_hold: got %h expected %h", got, {exp_f, 2'b10});
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b0;
        #1;
        got = {address, data, valid, overrun};
        checks++;
        if (got !== 10'h000) begin
            failures++;
            $display("FAIL async_reset: got %h expected %h", got, 10'h000);
        end
        tick();
        rst = 1'b1;
        tick();
        got = {address, data, valid, overrun};
        checks++;
        if (got !== 10'h000) begin
            failures++;
            $display("FAIL after_reset: got %h expected %h", got, 10'h000);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second_frame();
        test_long_strobe();
        test_overrun_and_b2b();
        test_async_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
